// File: rtl/fifo_pkg.sv
// Shared helpers and read-mode encoding for the fifo_flags FIFO.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Pointers wrap modulo the storage depth; full/empty come from the count instead.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned aw);
        return (ptr + 32'd1) % depth(aw);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = depth(AWIDTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with registered level flags, sticky errors and selectable FWFT read mode.
// Define FIFO_HWM_EN to add the o_hwm high-water-mark output.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 3,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 1,
    parameter int unsigned FWFT      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [DWIDTH-1:0] i_data_in,
    input  logic              i_clr_err,
    output logic [DWIDTH-1:0] o_data_out,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_empty,
    output logic              o_almost_full,
    output logic [AWIDTH:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
`ifdef FIFO_HWM_EN
    ,
    output logic [AWIDTH:0]   o_hwm
`endif
);

    localparam int unsigned   DEPTH     = depth(AWIDTH);
    localparam logic [AWIDTH:0] CNT_DEPTH = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] CNT_AFULL = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] CNT_AEMPTY = (AWIDTH+1)'(AEMPTY_TH);
    localparam logic [AWIDTH:0] CNT_ONE   = (AWIDTH+1)'(1);
    localparam fifo_mode_e    MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_empty;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_rej;
    logic              w_rd_rej;
    logic [AWIDTH:0]   w_count_nxt;
    logic [DWIDTH-1:0] w_rd_data;

    // A full FIFO still takes a write when the same edge pops a word.
    assign w_wr_acc = i_en & i_wr & (~r_full | i_rd);
    assign w_rd_acc = i_en & i_rd & ~r_empty;
    assign w_wr_rej = i_en & i_wr & r_full & ~i_rd;
    assign w_rd_rej = i_en & i_rd & r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= AWIDTH'(ptr_inc(32'(r_wr_ptr), AWIDTH));
            end
            if (w_rd_acc) begin
                r_rd_ptr <= AWIDTH'(ptr_inc(32'(r_rd_ptr), AWIDTH));
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == CNT_DEPTH);
            r_almost_empty <= (w_count_nxt <= CNT_AEMPTY);
            r_almost_full  <= (w_count_nxt >= CNT_AFULL);
            // A new error on the clearing edge wins over the clear.
            r_overflow     <= w_wr_rej | (r_overflow & ~i_clr_err);
            r_underflow    <= w_rd_rej | (r_underflow & ~i_clr_err);
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign o_data_out = r_empty ? '0 : w_rd_data;
    end else begin : g_std
        logic [DWIDTH-1:0] r_data_out;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_data_out <= '0;
            end else if (w_rd_acc) begin
                r_data_out <= w_rd_data;
            end
        end

        assign o_data_out = r_data_out;
    end

`ifdef FIFO_HWM_EN
    logic [AWIDTH:0] r_hwm;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hwm <= '0;
        end else if (i_clr_err || (w_count_nxt > r_hwm)) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign o_hwm = r_hwm;
`endif

    assign o_empty        = r_empty;
    assign o_full         = r_full;
    assign o_almost_empty = r_almost_empty;
    assign o_almost_full  = r_almost_full;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench: a registered-read and an FWFT instance share one stimulus stream.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout_std, dout_fwft;
    logic       empty, full, aempty, afull, ovf, udf;
    logic [3:0] count;
    logic       empty_f, full_f, aempty_f, afull_f, ovf_f, udf_f;
    logic [3:0] count_f;
`ifdef FIFO_HWM_EN
    logic [3:0] hwm, hwm_f;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_flags #(
        .DWIDTH (8), .AWIDTH (3), .AFULL_TH (6), .AEMPTY_TH (1), .FWFT (0)
    ) dut_std (
        .i_clk (clk), .i_rst (rst), .i_en (en), .i_wr (wr), .i_rd (rd),
        .i_data_in (din), .i_clr_err (clr_err), .o_data_out (dout_std),
        .o_empty (empty), .o_full (full), .o_almost_empty (aempty),
        .o_almost_full (afull), .o_count (count), .o_overflow (ovf),
        .o_underflow (udf)
`ifdef FIFO_HWM_EN
        , .o_hwm (hwm)
`endif
    );

    fifo_flags #(
        .DWIDTH (8), .AWIDTH (3), .AFULL_TH (6), .AEMPTY_TH (1), .FWFT (1)
    ) dut_fwft (
        .i_clk (clk), .i_rst (rst), .i_en (en), .i_wr (wr), .i_rd (rd),
        .i_data_in (din), .i_clr_err (clr_err), .o_data_out (dout_fwft),
        .o_empty (empty_f), .o_full (full_f), .o_almost_empty (aempty_f),
        .o_almost_full (afull_f), .o_count (count_f), .o_overflow (ovf_f),
        .o_underflow (udf_f)
`ifdef FIFO_HWM_EN
        , .o_hwm (hwm_f)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; rd = 1'b0; din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop();
        wr = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"}, count, 0);
        check({tag, " empty"}, empty, 1);
        check({tag, " full"}, full, 0);
        check({tag, " aempty"}, aempty, 1);
        check({tag, " afull"}, afull, 0);
        check({tag, " ovf"}, ovf, 0);
        check({tag, " udf"}, udf, 0);
        check({tag, " dout_std"}, dout_std, 0);
        check({tag, " dout_fwft"}, dout_fwft, 0);
        check({tag, " count_fwft"}, count_f, 0);
`ifdef FIFO_HWM_EN
        check({tag, " hwm"}, hwm, 0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Fill 1..8: flags track count on the same edge
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            check($sformatf("fill%0d count", i), count, i);
            check($sformatf("fill%0d aempty", i), aempty, (i <= 1) ? 1 : 0);
            check($sformatf("fill%0d afull", i), afull, (i >= 6) ? 1 : 0);
            check($sformatf("fill%0d full", i), full, (i == 8) ? 1 : 0);
            check($sformatf("fill%0d fwft head", i), dout_fwft, 1);
        end
        push(8'h09);
        check("ovf set", ovf, 1);
        check("ovf count", count, 8);
        check("ovf no udf", udf, 0);

        // Drain: registered output appears after the rd edge, FWFT shows the head beforehand
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d fwft pre", i), dout_fwft, i);
            pop();
            check($sformatf("drain%0d dout", i), dout_std, i);
            check($sformatf("drain%0d count", i), count, 8 - i);
        end
        check("drain empty", empty, 1);
        check("drain fwft zero", dout_fwft, 0);
        pop();
        check("udf set", udf, 1);
        check("udf dout hold", dout_std, 8'h08);
        check("udf fwft zero", dout_fwft, 0);
        check("udf count", count, 0);
`ifdef FIFO_HWM_EN
        check("hwm before clr", hwm, 8);
`endif
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr ovf", ovf, 0);
        check("clr udf", udf, 0);
`ifdef FIFO_HWM_EN
        check("hwm after clr", hwm, 0);
`endif

        // Simultaneous rd/wr on a full FIFO
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        wr = 1'b1; rd = 1'b1; din = 8'h0F;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("full rw count", count, 8);
        check("full rw full", full, 1);
        check("full rw dout", dout_std, 8'h11);
        check("full rw no ovf", ovf, 0);
        for (int i = 0; i < 8; i++) begin
            pop();
            check($sformatf("rw order%0d", i), dout_std, (i == 7) ? 8'h0F : 8'(8'h12 + i));
        end
        check("rw drained", count, 0);

        // Simultaneous rd/wr on an empty FIFO
        wr = 1'b1; rd = 1'b1; din = 8'h33;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("empty rw count", count, 1);
        check("empty rw udf", udf, 1);
        check("empty rw dout hold", dout_std, 8'h0F);
        check("empty rw fwft", dout_fwft, 8'h33);
        pop();
        check("empty rw pop", dout_std, 8'h33);

        // FWFT visibility of a single word
        push(8'hA5);
        tick();
        check("fwft a5", dout_fwft, 8'hA5);
        check("fwft a5 count", count_f, 1);
        check("std a5 hold", dout_std, 8'h33);
        pop();
        check("fwft pop empty", empty_f, 1);
        check("fwft pop zero", dout_fwft, 0);
        check("std pop a5", dout_std, 8'hA5);

        // clrErr acts even with en low
        en = 1'b0; clr_err = 1'b1;
        tick();
        en = 1'b1; clr_err = 1'b0;
        check("clr en0 udf", udf, 0);

        // en low freezes state
        for (int i = 0; i < 5; i++) push(8'(8'h21 + i));
        check("pre en0 count", count, 5);
        en = 1'b0; wr = 1'b1; din = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("en0 count%0d", i), count, 5);
            check($sformatf("en0 ovf%0d", i), ovf, 0);
        end
        en = 1'b1; wr = 1'b0;
        check("en0 dout hold", dout_std, 8'hA5);

        // Reset beats an in-flight rd/wr
        rst = 1'b1; wr = 1'b1; rd = 1'b1; din = 8'h55;
        tick();
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        check_reset_state("rst mid");

        // Interleaved traffic across the pointer wrap
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        for (int k = 0; k < 20; k++) begin
            push(8'(8'h43 + k));
            pop();
            check($sformatf("wrap%0d", k), dout_std, 8'(8'h40 + k));
        end
        check("wrap count", count, 3);
        check("wrap fwft head", dout_fwft, 8'h54);
`ifdef FIFO_HWM_EN
        check("wrap hwm", hwm, 4);
`endif
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("final ovf", ovf, 0);
        check("final udf", udf, 0);
`ifdef FIFO_HWM_EN
        check("final hwm", hwm, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock byte FIFO.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer stages on one clock domain, e.g. UART or stream buffering.

Parameters:
- DWIDTH, 8, data word width in bits.
- AWIDTH, 3, address width; DEPTH = 2**AWIDTH entries.
- AFULL_TH, 6, almostFull asserts when count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 1, almostEmpty asserts when count <= AEMPTY_TH. Legal range 0..DEPTH-1.
- FWFT, 0, read mode. 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable. When 0, no state changes except rst and clrErr.
- wr  in  1  write request.
- rd  in  1  read request.
- dataIn  in  DWIDTH  write data.
- clrErr  in  1  clears overflow/underflow; synchronous, one cycle.
- dataOut  out  DWIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almostEmpty  out  1  count <= AEMPTY_TH.
- almostFull  out  1  count >= AFULL_TH.
- count  out  AWIDTH+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset values: count=0, empty=1, full=0, almostEmpty=1, almostFull=0, overflow=0, underflow=0, dataOut=0, wrPtr=rdPtr=0. Memory contents are not reset.
- Reset takes priority over everything, including an in-flight rd/wr on the same edge.
- Accepted write: en & wr & (!full | rd). Stores dataIn at wrPtr; wrPtr increments modulo DEPTH.
- Accepted read: en & rd & !empty. rdPtr increments modulo DEPTH.
- Write rejected (en & wr & full & !rd): data dropped, overflow set, no other state change.
- Read rejected (en & rd & empty): underflow set. dataOut holds in FWFT=0 and stays 0 in FWFT=1.
- Simultaneous rd & wr:
  - When full, both are accepted and count is unchanged.
  - When empty, the write is accepted, the read is rejected (underflow set), and count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- count updates on the same edge as the accepted operation: +1 for write only, -1 for read only.
- All flags are registered and consistent with the new count on the same edge. Flags never lag count.
- FWFT=0: on an accepted read, dataOut <= mem[rdPtr] at that edge (1-cycle latency). Otherwise dataOut holds.
- FWFT=1: dataOut = mem[rdPtr] whenever !empty, else 0. The first write into an empty FIFO is visible on dataOut the cycle after the write edge. rd pops the displayed word.
- en=0: rd/wr are ignored, dataOut and all flags hold, and overflow/underflow are not set.
- clrErr clears both error flags regardless of en. If clrErr coincides with a new error event, the error wins and the flag stays 1.
- Pointer wrap: a full/empty distinction comes from count, not from pointer equality.

Optional Feature:
- Macro FIFO_HWM_EN adds output hwm [AWIDTH:0], the high-water mark.
  - hwm is registered and equals the maximum count since reset or clrErr.
  - It updates on the same edge as count when newCount > hwm.
  - Reset value is 0; clrErr loads it with the current count.
- Without the macro, the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - localparam-style helper functions depth(AWIDTH) and ptr-increment-with-wrap;
  - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e, used for decoding FWFT.
- Sub-module fifo_ram: simple dual-port memory, DEPTH x DWIDTH, with synchronous write and asynchronous read. The top handles pointers, count, flags and the dataOut register.

Test Plan (DWIDTH=8, AWIDTH=3, AFULL_TH=6, AEMPTY_TH=1):
- Fill: after reset, write 1..8 with en=1 → count steps 1..8; almostEmpty drops at count=2; almostFull rises at count=6; full=1 after the 8th write. A 9th write (0x09) sets overflow and leaves count=8.
- Drain, FWFT=0: read 8 times → dataOut 1..8, each one cycle after its rd edge. empty=1 after the 8th read. A 9th read sets underflow and dataOut holds 8.
- Simultaneous rd/wr:
  - Full FIFO with rd=wr=1 and dataIn=0x0F → count stays 8, the next read order continues, 0x0F is last.
  - Empty FIFO with rd=wr=1 → count=1, underflow=1.
- FWFT=1: write 0xA5 into an empty FIFO → dataOut=0xA5 the next cycle with rd=0. rd=1 → empty=1 and dataOut=0.
- en/reset: with en=0 and wr=1 for 3 cycles, count is unchanged and no error is set. Assert rst while count=5 with rd=wr=1 → all outputs at reset values on the next cycle.
- Wrap/clrErr: perform 20 interleaved write/read pairs → data order preserved across the pointer wrap. Pulse clrErr → overflow=underflow=0. With FIFO_HWM_EN, hwm=8 before clrErr and equals count after it.
